// File: rtl/hevc_pkg.sv
// Shared constants, FSM type and arithmetic helpers for the HEVC dequantization stage.
package hevc_pkg;

  localparam int QP_MAX = 51;

  localparam logic [6:0] LEVEL_SCALE [0:5] = '{7'd40, 7'd45, 7'd51, 7'd57, 7'd64, 7'd72};

  typedef enum logic [2:0] {
    ST_FILL,
    ST_FLUSH,
    ST_ISSUE_LO,
    ST_ISSUE_HI,
    ST_RELEASE
  } state_t;

  function automatic int bd_shift(input int n, input int bit_depth);
    return bit_depth + $clog2(n) - 5;
  endfunction

  function automatic logic [5:0] qp_clamp(input logic [5:0] qp);
    return (qp > 6'(QP_MAX)) ? 6'(QP_MAX) : qp;
  endfunction

  function automatic logic [3:0] qp_per(input logic [5:0] qp);
    return 4'(qp_clamp(qp) / 6'd6);
  endfunction

  function automatic logic [2:0] qp_rem(input logic [5:0] qp);
    return 3'(qp_clamp(qp) % 6'd6);
  endfunction

  function automatic logic signed [15:0] clip16(input logic signed [39:0] v);
    if (v > 40'sd32767)
      return 16'sh7fff;
    else if (v < -40'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/hevc_dequant_stage_if.sv
// Level stream into the dequant stage: valid/ready handshake carrying level and block QP.
interface hevc_dequant_stage_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_level;
  logic [5:0]         in_qp;

  modport master (output in_valid, output in_level, output in_qp, input in_ready);
  modport slave  (input in_valid, input in_level, input in_qp, output in_ready);
endinterface

// File: rtl/hevc_dequant_scaler.sv
// Two-stage dequant pipeline: S1 registers level*16*levelScale, S2 shifts/rounds/clips into the block write.
module hevc_dequant_scaler
  import hevc_pkg::*;
#(
  parameter int N         = 4,
  parameter int BIT_DEPTH = 8,
  parameter int IW        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] in_level,
  input  logic [3:0]         in_per,
  input  logic [2:0]         in_rem,
  input  logic [IW-1:0]      in_idx,
  output logic               wr_valid,
  output logic [IW-1:0]      wr_idx,
  output logic signed [15:0] wr_data
);
  localparam int BDS = bd_shift(N, BIT_DEPTH);
  localparam logic signed [39:0] RND = 40'sd1 <<< (BDS - 1);

  logic signed [27:0] prod_d, prod_q;
  logic [3:0]         per_q;
  logic signed [39:0] scaled, rounded;

  // |level*16*72| stays below 2^27, so a 28-bit product is exact
  assign prod_d = (28'(in_level) * 28'(LEVEL_SCALE[in_rem])) <<< 4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_valid <= 1'b0;
    else        wr_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      prod_q <= prod_d;
      per_q  <= in_per;
      wr_idx <= in_idx;
    end
  end

  assign scaled  = 40'(prod_q) <<< per_q;
  assign rounded = scaled + RND;
  assign wr_data = clip16(rounded >>> BDS);

endmodule

// File: rtl/hevc_dequant_stage.sv
// HEVC inverse-quantization stage: assembles levels into an NxN block and sequences the IDCT start/done handshake.
// Define HEVC_DEQUANT_DBUF_EN for a two-bank block buffer that keeps filling while the other bank is issued.
module hevc_dequant_stage
  import hevc_pkg::*;
#(
  parameter int N         = 4,
  parameter int BIT_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hevc_dequant_stage_if.slave  strm,
  output logic signed [15:0]   x [0:N-1][0:N-1],
  output logic                 idct_start,
  input  logic                 idct_done,
  output logic [15:0]          blk_count
);
  // state       | meaning
  // ST_FILL     | accepting levels (single bank) / waiting for a full bank to issue
  // ST_FLUSH    | two cycles for the last pipeline writes to land
  // ST_ISSUE_LO | start high, wait for done low (drop stale done)
  // ST_ISSUE_HI | start high, wait for done high
  // ST_RELEASE  | start low, count the handoff, free the bank

  localparam int LN = $clog2(N);
  localparam int KW = 2 * LN;
  localparam logic [KW-1:0] K_LAST = '1;
`ifdef HEVC_DEQUANT_DBUF_EN
  localparam int IW = KW + 1;
`else
  localparam int IW = KW;
`endif

  state_t             state, state_d;
  logic [KW-1:0]      k;
  logic               in_ready_q, in_ready_d;
  logic               flush_tmr;
  logic [3:0]         per_lat, per_cur;
  logic [2:0]         rem_lat, rem_cur;
  logic               acc, last_acc, blk_full;
  logic [IW-1:0]      acc_idx;
  logic               wr_valid;
  logic [IW-1:0]      wr_idx;
  logic signed [15:0] wr_data;

  assign strm.in_ready = in_ready_q;
  assign acc        = strm.in_valid && in_ready_q;
  assign last_acc   = acc && (k == K_LAST);
  assign idct_start = (state == ST_ISSUE_LO) || (state == ST_ISSUE_HI);
  assign per_cur    = (k == '0) ? qp_per(strm.in_qp) : per_lat;
  assign rem_cur    = (k == '0) ? qp_rem(strm.in_qp) : rem_lat;

`ifdef HEVC_DEQUANT_DBUF_EN
  logic               fill_bank, issue_bank;
  logic [1:0]         full, full_d;
  logic signed [15:0] mem [0:1][0:N-1][0:N-1];

  always_comb begin
    full_d = full;
    if (last_acc) full_d[fill_bank] = 1'b1;
    if (state == ST_RELEASE) full_d[issue_bank] = 1'b0;
  end

  assign blk_full   = full_d[issue_bank];
  assign acc_idx    = {fill_bank, k};
  assign in_ready_d = !full_d[fill_bank ^ last_acc];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full       <= '0;
      fill_bank  <= 1'b0;
      issue_bank <= 1'b0;
    end else begin
      full <= full_d;
      if (last_acc) fill_bank <= ~fill_bank;
      if (state == ST_RELEASE) issue_bank <= ~issue_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid) mem[wr_idx[KW]][wr_idx[KW-1:LN]][wr_idx[LN-1:0]] <= wr_data;
  end

  always_comb begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        x[r][c] = mem[issue_bank][r][c];
  end
`else
  assign blk_full   = last_acc;
  assign acc_idx    = k;
  assign in_ready_d = (state_d == ST_FILL);

  always_ff @(posedge clk) begin
    if (wr_valid) x[wr_idx[KW-1:LN]][wr_idx[LN-1:0]] <= wr_data;
  end
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      ST_FILL:     if (blk_full) state_d = ST_FLUSH;
      ST_FLUSH:    if (flush_tmr == 1'b0) state_d = ST_ISSUE_LO;
      ST_ISSUE_LO: if (!idct_done) state_d = ST_ISSUE_HI;
      ST_ISSUE_HI: if (idct_done) state_d = ST_RELEASE;
      ST_RELEASE:  state_d = ST_FILL;
      default:     state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_FILL;
      k          <= '0;
      in_ready_q <= 1'b0;
      flush_tmr  <= 1'b0;
      blk_count  <= '0;
      per_lat    <= '0;
      rem_lat    <= '0;
    end else begin
      state      <= state_d;
      in_ready_q <= in_ready_d;
      flush_tmr  <= (state == ST_FLUSH) ? 1'b0 : 1'b1;
      if (acc) k <= k + KW'(1);
      if (acc && (k == '0)) begin
        per_lat <= qp_per(strm.in_qp);
        rem_lat <= qp_rem(strm.in_qp);
      end
      if (state == ST_RELEASE) blk_count <= blk_count + 16'd1;
    end
  end

  hevc_dequant_scaler #(
    .N         (N),
    .BIT_DEPTH (BIT_DEPTH),
    .IW        (IW)
  ) u_scaler (
    .clk      (clk),
    .reset    (reset),
    .in_valid (acc),
    .in_level (strm.in_level),
    .in_per   (per_cur),
    .in_rem   (rem_cur),
    .in_idx   (acc_idx),
    .wr_valid (wr_valid),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data)
  );

endmodule

// File: tb/tb_hevc_dequant_stage.sv
// Scoreboard bench for hevc_dequant_stage: directed and random blocks against a behavioural dequant model.
module tb_hevc_dequant_stage;
  localparam int N         = 4;
  localparam int BIT_DEPTH = 8;
  localparam int NN        = N * N;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] x [0:N-1][0:N-1];
  logic               idct_start;
  logic               idct_done = 1'b1;
  logic [15:0]        blk_count;

  int checks = 0;
  int errors = 0;
  int exp_blk = 0;
  int idct_lat = 6;
  logic signed [15:0] sb [$];

  hevc_dequant_stage_if strm();

  hevc_dequant_stage #(.N(N), .BIT_DEPTH(BIT_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .strm       (strm),
    .x          (x),
    .idct_start (idct_start),
    .idct_done  (idct_done),
    .blk_count  (blk_count)
  );

  always #5 clk = ~clk;

`ifdef HEVC_DEQUANT_DBUF_EN
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
`endif

  // Reference: flat-matrix HEVC dequant with floor rounding, computed in 64-bit integers
  function automatic logic signed [15:0] ref_deq(input int level, input int qp);
    int     scale_tab [6] = '{40, 45, 51, 57, 64, 72};
    int     q, bds;
    longint v;
    q   = (qp > 51) ? 51 : qp;
    bds = BIT_DEPTH + $clog2(N) - 5;
    v   = longint'(level) * 16 * scale_tab[q % 6] * (longint'(1) << (q / 6));
    v   = (v + (longint'(1) << (bds - 1))) >>> bds;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the level was accepted.
  task automatic put(input logic signed [15:0] lv, input logic [5:0] q);
    logic rdy;
    int   guard = 0;
    strm.in_valid = 1'b1;
    strm.in_level = lv;
    strm.in_qp    = q;
    forever begin
      rdy = strm.in_ready;
      @(negedge clk);
      if (rdy) break;
      guard++;
      if (guard > 3000) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    strm.in_valid = 1'b0;
  endtask

  task automatic send_block(input int qp, input int lv [NN], input int gap_pct, input int n_lev);
    for (int i = 0; i < n_lev; i++) begin
      while ($urandom_range(99) < gap_pct) @(negedge clk);
      put(16'(lv[i]), (i == 0) ? 6'(qp) : 6'($urandom_range(63)));
    end
    if (n_lev == NN)
      for (int i = 0; i < NN; i++) sb.push_back(ref_deq(lv[i], qp));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || idct_start) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n < 5000) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // IDCT model: drops done a couple of cycles after start, raises it after idct_lat and leaves it stale-high.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (idct_start) begin
        repeat (2) begin @(posedge clk); #1; end
        idct_done = 1'b0;
        for (int i = 0; i < idct_lat && idct_start; i++) begin @(posedge clk); #1; end
        if (idct_start) idct_done = 1'b1;
        while (idct_start) begin @(posedge clk); #1; end
      end
    end
  end

  // Monitor: each idct_start rise is a handoff; x is compared against the oldest expected block.
  initial begin
    logic signed [15:0] exp_v [NN];
    bit got, saw_low, moved, rdy_hi;
    int n;
    forever begin
      @(negedge clk);
      if (!reset) exp_blk = 0;
      else if (idct_start) begin
        got = (sb.size() >= NN);
        chk("handoff_expected", got ? 1 : 0, 1);
        if (got)
          for (int i = 0; i < NN; i++) begin
            exp_v[i] = sb.pop_front();
            checks++;
            if (x[i / N][i % N] !== exp_v[i]) begin
              errors++;
              $display("FAIL x[%0d][%0d]: got %0d expected %0d", i / N, i % N, x[i / N][i % N], exp_v[i]);
            end
          end
        saw_low = 0; moved = 0; rdy_hi = 0; n = 0;
        while (idct_start && reset && n < 3000) begin
          if (!idct_done) saw_low = 1;
          if (got)
            for (int i = 0; i < NN; i++) if (x[i / N][i % N] !== exp_v[i]) moved = 1;
`ifndef HEVC_DEQUANT_DBUF_EN
          if (strm.in_ready) rdy_hi = 1;
`endif
          @(negedge clk);
          n++;
        end
        if (!reset) exp_blk = 0;
        else begin
          chk("issue_timeout", (n < 3000) ? 1 : 0, 1);
          chk("done_low_seen_before_release", saw_low ? 1 : 0, 1);
          chk("x_stable_during_issue", moved ? 1 : 0, 0);
          chk("in_ready_low_during_issue", rdy_hi ? 1 : 0, 0);
          exp_blk++;
          @(negedge clk);
          chk("blk_count", blk_count, exp_blk);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int lv [NN];
    int dq [6] = '{0, 4, 6, 0, 51, 63};
`ifdef HEVC_DEQUANT_DBUF_EN
    int c0;
`endif
    strm.in_valid = 1'b0;
    strm.in_level = '0;
    strm.in_qp    = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", strm.in_ready, 0);
    chk("reset_idct_start", idct_start, 0);
    chk("reset_blk_count", blk_count, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", strm.in_ready, 1);

    // Directed: unit levels, negative rounding and saturation at qp 51 / 63
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NN; i++)
        lv[i] = (b == 3) ? -1 : (b >= 4) ? ((i % 2 == 1) ? -32768 : 32767) : 1;
      send_block(dq[b], lv, 0, NN);
    end

    // Random levels and QP with ~50% valid gaps
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NN; i++)
        lv[i] = ($urandom_range(3) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(200)) - 100;
      send_block(int'($urandom_range(63)), lv, 50, NN);
    end
    wait_idle();

    // Reset mid-fill at k=7, then a fresh block
    for (int i = 0; i < NN; i++) lv[i] = int'($urandom_range(2000)) - 1000;
    send_block(30, lv, 0, 7);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("fill_reset_in_ready", strm.in_ready, 0);
    chk("fill_reset_idct_start", idct_start, 0);
    chk("fill_reset_blk_count", blk_count, 0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    send_block(17, lv, 0, NN);
    wait_idle();

    // Reset while waiting for done in ISSUE_HI
    idct_lat = 40;
    send_block(45, lv, 0, NN);
    begin
      int n = 0;
      while (!idct_start && n < 100) begin @(negedge clk); n++; end
    end
    chk("start_rise_before_issue_reset", idct_start, 1);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("issue_reset_idct_start", idct_start, 0);
    chk("issue_reset_in_ready", strm.in_ready, 0);
    chk("issue_reset_blk_count", blk_count, 0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    idct_lat = 6;
    for (int i = 0; i < NN; i++) lv[i] = int'($urandom_range(600)) - 300;
    send_block(12, lv, 30, NN);
    wait_idle();

`ifdef HEVC_DEQUANT_DBUF_EN
    // Long IDCT: second block fills during issue, third stalls until release
    idct_lat = 100;
    send_block(20, lv, 0, NN);
    c0 = cyc;
    send_block(33, lv, 0, NN);
    chk("dbuf_second_fill_cycles", cyc - c0, NN);
    chk("dbuf_issue_overlaps_fill", idct_start, 1);
    chk("dbuf_both_full_in_ready", strm.in_ready, 0);
    send_block(40, lv, 0, NN);
    wait_idle();
    idct_lat = 6;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hevc_dequant_stage.md
# hevc_dequant_stage

HEVC inverse-quantization stage sitting directly upstream of the 2-D IDCT. It accepts quantized coefficient levels in raster order over a valid/ready stream. Each level is scaled with the flat-matrix HEVC formula for the block QP, rounded and clipped, then assembled into an N×N block buffer. The completed block is driven on the IDCT `x` array and the IDCT `start`/`done` handshake is sequenced here.

## Interface
- `N`, 4: transform size (4, 8, 16 or 32).
- `BIT_DEPTH`, 8: sample bit depth; sets bdShift = BIT_DEPTH + log2(N) − 5.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-low.
- `in_valid`  in  1: `in_level` and `in_qp` are valid.
- `in_ready`  out  1: stage accepts a level this cycle.
- `in_level`  in  signed 16: quantized level.
- `in_qp`  in  6: block QP, sampled with the first level of each block; values >51 are treated as 51.
- `x`  out  signed 16 [0:N-1][0:N-1]: dequantized block for the IDCT.
- `idct_start`  out  1: IDCT start, level-held.
- `idct_done`  in  1: IDCT done.
- `blk_count`  out  16: completed handoffs, wraps at 2^16.

## Operation
- Transfer occurs when `in_valid && in_ready`. The coefficient counter `k` runs from 0 to N²−1 and wraps to 0 after the last level. Level k goes to `x[k/N][k%N]`.
- QP is latched when k==0. Precompute `per = qp/6` and `rem = qp%6`.
- levelScale = {40,45,51,57,64,72}[rem].
- Scaling: `s = (level × 16 × levelScale) << per`. Use a 40-bit signed intermediate.
- Output value: `(s + (1 << (bdShift−1))) >>> bdShift`, clipped to [−32768, 32767].
- FSM states:
  - FILL: `in_ready`=1 until the last level is accepted.
  - FLUSH: waits for the 2 pipeline writes to retire.
  - ISSUE_LO: `idct_start`=1; waits for `idct_done`==0. This rejects the stale done left from the previous block.
  - ISSUE_HI: `idct_start`=1; waits for `idct_done`==1.
  - RELEASE: `idct_start`=0 for one cycle; increments `blk_count`; goes to FILL.
- `x` is held stable from FLUSH exit until RELEASE. The IDCT reads it combinationally throughout its run.
- Reset asserted mid-operation aborts everything:
  - state returns to FILL, k to 0, pipeline valids clear;
  - `idct_start`, `in_ready` and `blk_count` go to 0.
  - `x` contents are not reset.

## Timing
- Reset values: `in_ready`=0, `idct_start`=0, `blk_count`=0. `in_ready` rises on the first clock after reset deassertion.
- `in_ready` is registered and is never combinationally dependent on `in_valid`.
- Two-stage pipeline:
  - S1 registers `level × 16 × levelScale`.
  - S2 applies shift, round and clip, and writes `x`.
  - Level accepted at cycle t is visible in `x` at t+2.
- Single-buffer block turnaround:
  - last accept at t; FLUSH spans t+1..t+2;
  - ISSUE_LO entered at t+3, with `idct_start` high from t+3;
  - then IDCT latency;
  - RELEASE lasts 1 cycle, then FILL with `in_ready` high.
- `in_valid` low mid-block stalls k without loss. Bubbles propagate through the pipeline.
- An accept on the last level with `in_ready` dropping the next cycle is legal. No level is accepted while not in FILL.

## Configuration
- `HEVC_DEQUANT_DBUF_EN` defined:
  - two banks of the block buffer;
  - FILL continues into the free bank while the other bank is in ISSUE/RELEASE;
  - `x` is muxed from the issuing bank;
  - `in_ready` drops only when both banks are full.
  - Banks alternate 0,1,0,… after reset.
- Undefined: one bank; `in_ready`=0 outside FILL, per the single-buffer turnaround above.

## Structure
- Shared package `hevc_pkg`:
  - levelScale array;
  - QP max (51);
  - `clip16` function;
  - bdShift function of N and BIT_DEPTH;
  - FSM state typedef.
- One sub-module, `hevc_dequant_scaler`: the 2-stage scale/round/clip pipeline, with valid and index carried alongside the data.
- Top level: counter, FSM, bank storage and handshake.

## Test plan
- N=4, BIT_DEPTH=8, qp=0, all 16 levels = 1 -> every `x` = 20; single `idct_start` rise; `blk_count`=1 after RELEASE.
- qp=4 level=1 -> 32; qp=6 level=1 -> 40; qp=0 level=−1 -> −20 (floor rounding).
- qp=51 with level 32767 -> 32767, and with level −32768 -> −32768; qp=63 gives identical results.
- Random `in_valid` gaps (about 50%) over 3 back-to-back blocks -> `x` matches the reference model; IDCT model `done` is stale-high at the second start and `idct_start` still waits for `done` to drop before accepting.
- Reset pulled low at k=7 while in FILL, then at ISSUE_HI -> `idct_start`=0, `in_ready`=0 during reset; the next block restarts at k=0 with its fresh QP.
- With `HEVC_DEQUANT_DBUF_EN`, IDCT held 100 cycles -> the second block fills during issue with `in_ready`=1; the third block stalls with `in_ready`=0 until RELEASE.
